// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Consumer side of a dual-word instruction memory port. Drives a registered
//   byte fetch PC and a one-cycle fetch strobe, captures the returned ins0/ins1
//   pair one cycle after the strobe, queues instructions with their PCs and
//   presents up to two in-order instructions per cycle to a dual-issue decoder.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   pc, fetch_en        fetch address / strobe to memory (both registered)
//   ins0, ins1          memory words at pc and pc+4 (valid the cycle after fetch_en)
//   dec_valid           bit0 slot0 valid, bit1 slot1 valid (bit1 implies bit0)
//   dec_ins0/1, dec_pc0/1  oldest / second-oldest queued instruction and PC
//   dec_take            instructions consumed this cycle (0..2)
//   redirect, redirect_pc  flush queue and restart fetch at redirect_pc
//   halt                level, suppresses new fetches
//   fetch_oob           sticky, a fetch was suppressed because pc > PC_LIMIT
//   dbg_state           current FSM state (IDLE=0, REQ=1, RESP=2, HOLD=3)
//
// Optional build macro FETCH_PERF_EN adds saturating counters:
//   perf_fetches (fetch_en pulses) and perf_stalls (cycles in HOLD with halt=0).
//
// Decoder handshake: dec_valid advertises how many head entries are valid this
// cycle; dec_take states how many of them the decoder consumes at the next
// rising edge. Entries are removed only by dec_take, never by the producer, and
// dec_take must not exceed the advertised count (it is clamped if it does).
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_LIMIT = 32'd1008
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic        fetch_en,
  input  logic [31:0] ins0,
  input  logic [31:0] ins1,
  output logic [1:0]  dec_valid,
  output logic [31:0] dec_ins0,
  output logic [31:0] dec_ins1,
  output logic [31:0] dec_pc0,
  output logic [31:0] dec_pc1,
  input  logic [1:0]  dec_take,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_oob,
  output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stalls
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, HOLD = 2'd3} state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic           fetch_en_q, fetch_en_d;
  logic           oob_q, oob_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    ins_q [DEPTH];
  logic [31:0]    ins_d [DEPTH];
  logic [31:0]    ipc_q [DEPTH];
  logic [31:0]    ipc_d [DEPTH];

  logic [1:0]     vcnt;
  logic [1:0]     take_eff;
  logic [PW-1:0]  head1, tail1;
  logic           push;
  logic           allow;

  // Decoder view, combinational from the head; invalid slots read as zero
  // because a flush does not clear the storage.
  always_comb begin
    dec_valid = 2'b00;
    vcnt      = 2'd0;
    if (count_q >= CW'(2)) begin
      dec_valid = 2'b11;
      vcnt      = 2'd2;
    end else if (count_q == CW'(1)) begin
      dec_valid = 2'b01;
      vcnt      = 2'd1;
    end
    head1    = head_q + PW'(1);
    dec_ins0 = dec_valid[0] ? ins_q[head_q] : 32'd0;
    dec_pc0  = dec_valid[0] ? ipc_q[head_q] : 32'd0;
    dec_ins1 = dec_valid[1] ? ins_q[head1]  : 32'd0;
    dec_pc1  = dec_valid[1] ? ipc_q[head1]  : 32'd0;
    take_eff = (dec_take > vcnt) ? vcnt : dec_take;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    oob_d   = oob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ins_d   = ins_q;
    ipc_d   = ipc_q;
    push    = 1'b0;
    allow   = 1'b0;
    tail1   = tail_q + PW'(1);
    if (redirect) begin
      // Flush wins over everything, including a capture due at this edge.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = redirect_pc;
      oob_d   = 1'b0;
      state_d = halt ? HOLD : REQ;
    end else begin
      push    = (state_q == RESP);
      head_d  = head_q + PW'(take_eff);
      count_d = count_q - CW'(take_eff) + (push ? CW'(2) : CW'(0));
      if (push) begin
        ins_d[tail_q] = ins0;
        ipc_d[tail_q] = pc_q;
        ins_d[tail1]  = ins1;
        ipc_d[tail1]  = pc_q + 32'd4;
        tail_d        = tail_q + PW'(2);
        pc_d          = pc_q + 32'd8;
      end
      // Free space is judged after this cycle's push and pop, so a fetch is
      // only launched when its whole response is guaranteed a slot.
      allow = (CW'(DEPTH) - count_d >= CW'(2)) && !halt && (pc_d <= PC_LIMIT);
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = RESP;
        default: begin
          state_d = allow ? REQ : HOLD;
          if (pc_d > PC_LIMIT) oob_d = 1'b1;
        end
      endcase
    end
    fetch_en_d = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_en_q <= 1'b0;
      oob_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= 32'd0;
        ipc_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_en_q <= fetch_en_d;
      oob_q      <= oob_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ins_q      <= ins_d;
      ipc_q      <= ipc_d;
    end
  end

  assign pc        = pc_q;
  assign fetch_en  = fetch_en_q;
  assign fetch_oob = oob_q;
  assign dbg_state = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_fetches_d = perf_fetches_q;
    perf_stalls_d  = perf_stalls_q;
    if (fetch_en_q && (perf_fetches_q != 32'hFFFF_FFFF))
      perf_fetches_d = perf_fetches_q + 32'd1;
    if ((state_q == HOLD) && !halt && (perf_stalls_q != 32'hFFFF_FFFF))
      perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetches_q <= 32'd0;
      perf_stalls_q  <= 32'd0;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_stalls  = perf_stalls_q;
`endif

  // Decoder must not consume more than is advertised.
  a_take_le_valid: assert property (@(posedge clk) disable iff (rst)
    (dec_take <= vcnt));
  // The allowance rule must make queue overflow unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (count_d <= CW'(DEPTH)));

endmodule
